// File: rtl/minimac_mdio_slave.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC/MDIO on sys_clk, decodes frames
// addressed to PHY_ADDR and serves a 32x16 register file with live status and fixed IDs.
module minimac_mdio_slave #(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter logic [15:0] PHY_ID1      = 16'h0022,
   parameter logic [15:0] PHY_ID2      = 16'h1610,
   parameter logic [15:0] CTRL_RESET   = 16'h3100,
   parameter int          PREAMBLE_LEN = 32
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic [15:0] status_i,
   output logic [15:0] ctrl_o,
   output logic        soft_rst,
   output logic        wr_stb,
   output logic [4:0]  wr_adr,
   output logic [15:0] wr_dat,
   output logic        busy
);

   localparam logic [5:0]  PRE_MIN   = 6'(PREAMBLE_LEN);
   localparam logic [5:0]  PRE_SAT   = 6'd32;
   localparam logic [15:0] CTRL_INIT = CTRL_RESET & 16'h7FFF;

   typedef enum logic [2:0] {
      S_PRE  = 3'd0,
      S_ST1  = 3'd1,
      S_OP   = 3'd2,
      S_PHYA = 3'd3,
      S_REGA = 3'd4,
      S_TA   = 3'd5,
      S_DATA = 3'd6
   } state_t;

   // Valid/ready does not apply here: every decode step is qualified by edge_evt alone,
   // and wr_stb/soft_rst are single-cycle pulses with wr_adr/wr_dat valid while wr_stb=1.
   state_t      state, state_n;
   logic [2:0]  mdc_sync;
   logic [1:0]  mdio_sync;
   logic        edge_evt, bit_in;

   logic [5:0]  pre_cnt, pre_cnt_n;
   logic [3:0]  bit_cnt, bit_cnt_n;
   logic        is_read, is_read_n;
   logic [3:0]  hdr_sh, hdr_sh_n;
   logic [4:0]  reg_adr, reg_adr_n;
   logic [15:0] dat_sh, dat_sh_n;
   logic [15:0] wdata, rd_mux;
   logic        oe_n, o_n, busy_n;
   logic        commit, abort, to_pre, soft_n;
   logic [15:0] regs [32];

   assign edge_evt = mdc_sync[1] & ~mdc_sync[2];
   assign bit_in   = mdio_sync[1];
   assign wdata    = {dat_sh[14:0], bit_in};
   assign soft_n   = commit && (reg_adr == 5'd0) && wdata[15];

   always_comb begin
      case (reg_adr)
         5'd0:    rd_mux = ctrl_o;
         5'd1:    rd_mux = status_i;
         5'd2:    rd_mux = PHY_ID1;
         5'd3:    rd_mux = PHY_ID2;
         default: rd_mux = regs[reg_adr];
      endcase
   end

   always_comb begin
      state_n   = state;
      pre_cnt_n = pre_cnt;
      bit_cnt_n = bit_cnt;
      is_read_n = is_read;
      hdr_sh_n  = hdr_sh;
      reg_adr_n = reg_adr;
      dat_sh_n  = dat_sh;
      oe_n      = mdio_oe;
      o_n       = mdio_o;
      busy_n    = busy;
      commit    = 1'b0;
      abort     = 1'b0;
      to_pre    = 1'b0;
      if (edge_evt) begin
         case (state)
            S_PRE: begin
               if (bit_in) begin
                  if (pre_cnt != PRE_SAT) pre_cnt_n = pre_cnt + 6'd1;
               end else if (pre_cnt >= PRE_MIN) begin
                  state_n   = S_ST1;
                  busy_n    = 1'b1;
                  pre_cnt_n = 6'd0;
               end else begin
                  pre_cnt_n = 6'd0;
               end
            end
            S_ST1: begin
               if (bit_in) begin
                  state_n   = S_OP;
                  bit_cnt_n = 4'd0;
               end else begin
                  abort = 1'b1;
               end
            end
            S_OP: begin
               if (bit_cnt == 4'd0) begin
                  hdr_sh_n  = {hdr_sh[2:0], bit_in};
                  bit_cnt_n = 4'd1;
               end else if (hdr_sh[0] != bit_in) begin
                  // 10 = read, 01 = write; equal bits are reserved opcodes
                  is_read_n = hdr_sh[0];
                  state_n   = S_PHYA;
                  bit_cnt_n = 4'd0;
               end else begin
                  abort = 1'b1;
               end
            end
            S_PHYA: begin
               hdr_sh_n = {hdr_sh[2:0], bit_in};
               if (bit_cnt == 4'd4) begin
                  if ({hdr_sh, bit_in} == PHY_ADDR) begin
                     state_n   = S_REGA;
                     bit_cnt_n = 4'd0;
                  end else begin
                     abort = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
            S_REGA: begin
               reg_adr_n = {reg_adr[3:0], bit_in};
               if (bit_cnt == 4'd4) begin
                  state_n   = S_TA;
                  bit_cnt_n = 4'd0;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
            S_TA: begin
               if (bit_cnt == 4'd0) begin
                  if (is_read) begin
                     oe_n      = 1'b1;
                     o_n       = 1'b0;
                     dat_sh_n  = rd_mux;
                     bit_cnt_n = 4'd1;
                  end else if (bit_in) begin
                     bit_cnt_n = 4'd1;
                  end else begin
                     abort = 1'b1;
                  end
               end else if (is_read) begin
                  o_n       = dat_sh[15];
                  dat_sh_n  = {dat_sh[14:0], 1'b0};
                  state_n   = S_DATA;
                  bit_cnt_n = 4'd15;
               end else if (!bit_in) begin
                  state_n   = S_DATA;
                  bit_cnt_n = 4'd15;
               end else begin
                  abort = 1'b1;
               end
            end
            S_DATA: begin
               // Read: the bit just sampled by the master was Dn; put Dn-1 on the wire.
               if (is_read) begin
                  if (bit_cnt == 4'd0) begin
                     o_n    = 1'b0;
                     to_pre = 1'b1;
                  end else begin
                     o_n       = dat_sh[15];
                     dat_sh_n  = {dat_sh[14:0], 1'b0};
                     bit_cnt_n = bit_cnt - 4'd1;
                  end
               end else begin
                  dat_sh_n = wdata;
                  if (bit_cnt == 4'd0) begin
                     commit = 1'b1;
                     to_pre = 1'b1;
                  end else begin
                     bit_cnt_n = bit_cnt - 4'd1;
                  end
               end
            end
            default: abort = 1'b1;
         endcase
         if (abort || to_pre) begin
            state_n   = S_PRE;
            pre_cnt_n = 6'd0;
            busy_n    = 1'b0;
            oe_n      = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         mdc_sync  <= 3'b000;
         mdio_sync <= 2'b00;
         state     <= S_PRE;
         pre_cnt   <= 6'd0;
         bit_cnt   <= 4'd0;
         is_read   <= 1'b0;
         hdr_sh    <= 4'd0;
         reg_adr   <= 5'd0;
         dat_sh    <= 16'd0;
         mdio_oe   <= 1'b0;
         mdio_o    <= 1'b0;
         busy      <= 1'b0;
         wr_stb    <= 1'b0;
         wr_adr    <= 5'd0;
         wr_dat    <= 16'd0;
         soft_rst  <= 1'b0;
         ctrl_o    <= CTRL_INIT;
         for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
      end else begin
         mdc_sync  <= {mdc_sync[1:0], mdc_i};
         mdio_sync <= {mdio_sync[0], mdio_i};
         state     <= state_n;
         pre_cnt   <= pre_cnt_n;
         bit_cnt   <= bit_cnt_n;
         is_read   <= is_read_n;
         hdr_sh    <= hdr_sh_n;
         reg_adr   <= reg_adr_n;
         dat_sh    <= dat_sh_n;
         mdio_oe   <= oe_n;
         mdio_o    <= o_n;
         busy      <= busy_n;
         wr_stb    <= commit;
         soft_rst  <= soft_n;
         if (commit) begin
            wr_adr <= reg_adr;
            wr_dat <= wdata;
            if (reg_adr == 5'd0) begin
               // soft reset clears the file first; the written value (bit 15 dropped) lands on top
               if (wdata[15]) begin
                  for (int i = 0; i < 32; i++) regs[i] <= 16'd0;
               end
               ctrl_o <= {1'b0, wdata[14:0]};
            end else if (reg_adr >= 5'd4) begin
               regs[reg_adr] <= wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_minimac_mdio_slave.sv
// Bench for minimac_mdio_slave: drives MDC/MDIO as a management master, scores read data
// and write strobes against a register model.
module tb_minimac_mdio_slave;

   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;

   logic        sys_clk, sys_rst, mdc_i, mdio_i, mdio_o, mdio_oe;
   logic [15:0] status_i, ctrl_o, wr_dat;
   logic        soft_rst, wr_stb, busy;
   logic [4:0]  wr_adr;

   minimac_mdio_slave dut (
      .sys_clk (sys_clk),  .sys_rst (sys_rst),
      .mdc_i   (mdc_i),    .mdio_i  (mdio_i),
      .mdio_o  (mdio_o),   .mdio_oe (mdio_oe),
      .status_i(status_i), .ctrl_o  (ctrl_o),
      .soft_rst(soft_rst), .wr_stb  (wr_stb),
      .wr_adr  (wr_adr),   .wr_dat  (wr_dat),
      .busy    (busy)
   );

   typedef struct {
      int          npre;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [1:0]  ta;
      logic [15:0] wd;
      logic [15:0] status;
      logic        resp;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   int          soft_cnt = 0;
   int          exp_soft = 0;
   logic [20:0] wr_q [$];
   logic [15:0] rd_q [$];
   logic [15:0] m_regs [32];
   logic [15:0] m_ctrl;
   vec_t        vecs [$];

   logic        smp_oe, smp_o, smp_busy;
   logic        f_any_oe, f_oe_pre_ta, f_oe_ta, f_o_ta, f_oe_data, f_oe_after, f_busy_mid, f_busy_after;
   logic [15:0] f_rd;

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard side for writes: every strobe must match the oldest expected write
   always @(negedge sys_clk) begin
      if (!sys_rst && soft_rst) soft_cnt++;
      if (!sys_rst && wr_stb) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_stb unexpected: got adr=%0h dat=%0h expected none", wr_adr, wr_dat);
         end else begin
            logic [20:0] e;
            e = wr_q.pop_front();
            if ({wr_adr, wr_dat} !== e) begin
               errors++;
               $display("FAIL wr_stb data: got adr=%0h dat=%0h expected adr=%0h dat=%0h",
                        wr_adr, wr_dat, e[20:16], e[15:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic mdc_bit(input logic b);
      mdio_i = b;
      repeat (5) @(negedge sys_clk);
      smp_oe   = mdio_oe;
      smp_o    = mdio_o;
      smp_busy = busy;
      mdc_i    = 1'b1;
      repeat (5) @(negedge sys_clk);
      mdc_i    = 1'b0;
      f_any_oe = f_any_oe | smp_oe;
   endtask

   task automatic send_header(input int npre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra);
      f_any_oe = 1'b0;
      repeat (npre) mdc_bit(1'b1);
      mdc_bit(1'b0);
      mdc_bit(1'b1);
      mdc_bit(op[1]);
      mdc_bit(op[0]);
      for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
      for (int i = 4; i >= 0; i--) mdc_bit(ra[i]);
   endtask

   task automatic run_frame(input vec_t v);
      send_header(v.npre, v.op, v.phy, v.ra);
      mdc_bit(v.ta[1]);
      f_oe_pre_ta = smp_oe;
      f_busy_mid  = smp_busy;
      mdc_bit(v.ta[0]);
      f_oe_ta = smp_oe;
      f_o_ta  = smp_o;
      f_oe_data = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         mdc_bit(v.wd[i]);
         f_rd[i]   = smp_o;
         f_oe_data = f_oe_data & smp_oe;
      end
      mdc_bit(1'b0);
      f_oe_after   = smp_oe;
      f_busy_after = smp_busy;
   endtask

   function automatic logic [15:0] model_rd(input logic [4:0] a);
      case (a)
         5'd0:    return m_ctrl;
         5'd1:    return status_i;
         5'd2:    return 16'h0022;
         5'd3:    return 16'h1610;
         default: return m_regs[a];
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
      m_ctrl = 16'h3100;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      status_i = v.status;
      if (v.resp && v.op == OP_RD) rd_q.push_back(model_rd(v.ra));
      if (v.resp && v.op == OP_WR) begin
         wr_q.push_back({v.ra, v.wd});
         if (v.ra == 5'd0) begin
            if (v.wd[15]) begin
               exp_soft++;
               for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
            end
            m_ctrl = v.wd & 16'h7FFF;
         end else if (v.ra >= 5'd4) begin
            m_regs[v.ra] = v.wd;
         end
      end
      run_frame(v);
      if (v.resp && v.op == OP_RD) begin
         check($sformatf("v%0d read data", idx), {16'h0, f_rd}, {16'h0, rd_q.pop_front()});
         check($sformatf("v%0d oe before TA1", idx), {31'h0, f_oe_pre_ta}, 32'd0);
         check($sformatf("v%0d oe after TA1", idx), {31'h0, f_oe_ta}, 32'd1);
         check($sformatf("v%0d TA2 bit", idx), {31'h0, f_o_ta}, 32'd0);
         check($sformatf("v%0d oe in data", idx), {31'h0, f_oe_data}, 32'd1);
         check($sformatf("v%0d oe after D0", idx), {31'h0, f_oe_after}, 32'd0);
      end
      if (v.resp) check($sformatf("v%0d busy mid", idx), {31'h0, f_busy_mid}, 32'd1);
      else        check($sformatf("v%0d no drive", idx), {31'h0, f_any_oe}, 32'd0);
      check($sformatf("v%0d busy end", idx), {31'h0, f_busy_after}, 32'd0);
      check($sformatf("v%0d writes drained", idx), wr_q.size(), 32'd0);
      check($sformatf("v%0d soft_rst count", idx), soft_cnt, exp_soft);
      check($sformatf("v%0d ctrl_o", idx), {16'h0, ctrl_o}, {16'h0, m_ctrl});
   endtask

   initial begin
      vec_t v;
      logic [4:0]  ra;
      logic [15:0] wd;

      vecs.push_back('{32, OP_RD, 5'd1, 5'd2,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd3,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd5,  2'b10, 16'hBEEF, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd5,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd31, 2'b10, 16'h1234, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd31, 2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd0,  2'b10, 16'h1040, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd0,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd2,  2'b10, 16'hAAAA, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd2,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd0,  2'b10, 16'h9140, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd5,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd31, 2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd0,  2'b10, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd2, 5'd2,  2'b10, 16'h0000, 16'h0000, 1'b0});
      vecs.push_back('{31, OP_RD, 5'd1, 5'd2,  2'b10, 16'h0000, 16'h0000, 1'b0});
      vecs.push_back('{31, OP_WR, 5'd1, 5'd6,  2'b10, 16'h5555, 16'h0000, 1'b0});
      vecs.push_back('{32, OP_WR, 5'd2, 5'd8,  2'b10, 16'h4321, 16'h0000, 1'b0});
      vecs.push_back('{32, OP_WR, 5'd1, 5'd7,  2'b11, 16'h1234, 16'h0000, 1'b0});
      vecs.push_back('{32, 2'b11, 5'd1, 5'd7,  2'b10, 16'h1234, 16'h0000, 1'b0});
      vecs.push_back('{32, 2'b00, 5'd1, 5'd7,  2'b10, 16'h1234, 16'h0000, 1'b0});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd1,  2'b10, 16'h0000, 16'h786D, 1'b1});
      vecs.push_back('{32, OP_RD, 5'd1, 5'd1,  2'b10, 16'h0000, 16'hA5C3, 1'b1});
      vecs.push_back('{40, OP_RD, 5'd1, 5'd3,  2'b10, 16'h0000, 16'h0000, 1'b1});
      for (int k = 0; k < 4; k++) begin
         ra = 5'($urandom_range(4, 31));
         wd = 16'($urandom_range(0, 65535));
         vecs.push_back('{32, OP_WR, 5'd1, ra, 2'b10, wd, 16'h0000, 1'b1});
         vecs.push_back('{32, OP_RD, 5'd1, ra, 2'b10, 16'h0000, 16'h0000, 1'b1});
      end

      sys_rst  = 1'b1;
      mdc_i    = 1'b0;
      mdio_i   = 1'b1;
      status_i = 16'h0000;
      model_reset();
      repeat (4) @(negedge sys_clk);
      check("reset mdio_oe",  {31'h0, mdio_oe},  32'd0);
      check("reset mdio_o",   {31'h0, mdio_o},   32'd0);
      check("reset busy",     {31'h0, busy},     32'd0);
      check("reset wr_stb",   {31'h0, wr_stb},   32'd0);
      check("reset soft_rst", {31'h0, soft_rst}, 32'd0);
      check("reset wr_adr",   {27'h0, wr_adr},   32'd0);
      check("reset wr_dat",   {16'h0, wr_dat},   32'd0);
      check("reset ctrl_o",   {16'h0, ctrl_o},   32'h3100);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      foreach (vecs[i]) apply_vec(i, vecs[i]);

      // reset in the middle of a read data phase, then a clean frame afterwards
      apply_vec(100, '{32, OP_WR, 5'd1, 5'd0, 2'b10, 16'h1000, 16'h0000, 1'b1});
      apply_vec(101, '{32, OP_WR, 5'd1, 5'd9, 2'b10, 16'h0F0F, 16'h0000, 1'b1});
      send_header(32, OP_RD, 5'd1, 5'd2);
      mdc_bit(1'b1);
      mdc_bit(1'b1);
      for (int i = 15; i >= 8; i--) begin
         mdc_bit(1'b1);
         f_rd[i] = smp_o;
      end
      check("mid-read upper byte", {24'h0, f_rd[15:8]}, 32'h00);
      check("mid-read oe before reset", {31'h0, mdio_oe}, 32'd1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      check("mid-read oe after reset",   {31'h0, mdio_oe}, 32'd0);
      check("mid-read busy after reset", {31'h0, busy},    32'd0);
      check("mid-read ctrl after reset", {16'h0, ctrl_o},  32'h3100);
      repeat (5) @(negedge sys_clk);
      mdc_bit(1'b0);
      apply_vec(102, '{32, OP_RD, 5'd1, 5'd2, 2'b10, 16'h0000, 16'h0000, 1'b1});
      apply_vec(103, '{32, OP_RD, 5'd1, 5'd0, 2'b10, 16'h0000, 16'h0000, 1'b1});
      apply_vec(104, '{32, OP_RD, 5'd1, 5'd9, 2'b10, 16'h0000, 16'h0000, 1'b1});

      repeat (10) @(negedge sys_clk);
      check("final writes drained", wr_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
